// File: rtl/bcd_to_bin_seq.sv
// Iterative BCD-to-binary converter (reverse double-dabble, one bit per cycle).
// Latency BIN_W cycles from accept to out_valid; optional BCD_CHECK_EN flags bad digits in 1 cycle.
// Backpressure: no overlap; in_ready low from accept until the DONE handshake, result held while out_ready=0.
module bcd_to_bin_seq #(
    parameter int DIGITS = 3,
    parameter int BIN_W  = 10,
    parameter int CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   din,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BIN_W-1:0]      dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  err
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                 state_q, state_d;
    logic [4*DIGITS-1:0]    bcd_q, bcd_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0]       dout_q, dout_d;
    logic                   out_valid_q, out_valid_d;
    logic                   in_ready_q, in_ready_d;
    logic                   err_q, err_d;

    logic [4*DIGITS-1:0]    sh_bcd, step_bcd;
    logic [BIN_W-1:0]       step_bin;
`ifdef BCD_CHECK_EN
    logic                   bad_digit;
`endif

    // One reverse double-dabble step: shift right, then pull every nibble >= 8 back by 3.
    always_comb begin
        {sh_bcd, step_bin} = {bcd_q, bin_q} >> 1;
        step_bcd = sh_bcd;
        for (int k = 0; k < DIGITS; k++) begin
            if (sh_bcd[4*k+3]) begin
                step_bcd[4*k +: 4] = sh_bcd[4*k +: 4] - 4'd3;
            end
        end
    end

`ifdef BCD_CHECK_EN
    always_comb begin
        bad_digit = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (din[4*k +: 4] > 4'd9) begin
                bad_digit = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d     = state_q;
        bcd_d       = bcd_q;
        bin_d       = bin_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bcd_d      = din;
                    bin_d      = '0;
                    cnt_d      = '0;
                    in_ready_d = 1'b0;
`ifdef BCD_CHECK_EN
                    if (bad_digit) begin
                        state_d     = DONE;
                        dout_d      = '0;
                        err_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = SHIFT;
                    end
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                bcd_d = step_bcd;
                bin_d = step_bin;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    state_d     = DONE;
                    dout_d      = step_bin;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    err_d       = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= IDLE;
            bcd_q       <= '0;
            bin_q       <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bcd_q       <= bcd_d;
            bin_q       <= bin_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign dout      = dout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Scoreboard bench for bcd_to_bin_seq: input monitor pushes reference results, output monitor pops and compares.
module tb_bcd_to_bin_seq;

    logic        CLK = 1'b0;
    logic        RST;
    logic [11:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  dout;
    logic        out_valid;
    logic        out_ready;
    logic        err;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    bit rnd_mode = 1'b0;

    typedef struct {
        logic [9:0] dout;
        logic       err;
        int         lat;
        int         acc;
    } exp_t;

    exp_t exp_q[$];

    bcd_to_bin_seq dut (
        .CLK       (CLK),
        .RST       (RST),
        .din       (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dout      (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .err       (err)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: decimal weighting of each digit.
    function automatic exp_t ref_model(input logic [11:0] v);
        exp_t e;
        int   sum = 0;
        bit   bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            int d = int'(v[4*k +: 4]);
            if (d > 9) bad = 1'b1;
            sum += d * (10 ** k);
        end
        e.dout = 10'(sum);
        e.err  = 1'b0;
        e.lat  = 10;
        e.acc  = 0;
`ifdef BCD_CHECK_EN
        if (bad) begin
            e.dout = '0;
            e.err  = 1'b1;
            e.lat  = 1;
        end
`endif
        return e;
    endfunction

    always @(negedge CLK) begin
        if (RST && in_valid && in_ready) begin
            exp_t e;
            e = ref_model(din);
            e.acc = cyc + 1;
            exp_q.push_back(e);
        end
    end

    bit         prev_ov = 1'b0;
    bit         prev_hs = 1'b0;
    logic [9:0] prev_dout;
    logic       prev_err;

    always @(negedge CLK) begin
        if (!RST) begin
            prev_ov = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) begin
                chk("out_valid_drop_after_hs", out_valid, 0);
                chk("in_ready_after_hs", in_ready, 1);
            end
            if (out_valid) chk("in_ready_low_while_valid", in_ready, 0);
            if (out_valid && !prev_ov) begin
                if (exp_q.size() == 0) chk("spurious_out_valid", 1, 0);
                else chk("latency", cyc - exp_q[0].acc, exp_q[0].lat);
            end
            if (out_valid && prev_ov && !prev_hs) begin
                chk("dout_stable", dout, prev_dout);
                chk("err_stable", err, prev_err);
            end
            if (out_valid && out_ready && exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("dout", dout, e.dout);
                chk("err", err, e.err);
            end
            prev_hs   = out_valid && out_ready;
            prev_ov   = out_valid;
            prev_dout = dout;
            prev_err  = err;
        end
    end

    always @(posedge CLK) begin
        if (rnd_mode) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [11:0] v);
        int t = 0;
        in_valid = 1'b1;
        din      = v;
        do begin
            @(negedge CLK);
            t++;
        end while (!in_ready && t < 300);
        if (!in_ready) chk("accept_timeout", 0, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic send_one(input logic [11:0] v);
        send(v);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 400) begin
            @(negedge CLK);
            t++;
        end
        chk("drain_timeout", (exp_q.size() == 0 && !out_valid), 1);
        chk("idle_in_ready", in_ready, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_out_valid();
        int t = 0;
        while (!out_valid && t < 50) begin
            @(negedge CLK);
            t++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] v;
        RST       = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_err", err, 0);
        RST = 1'b1;

        send_one(12'h999); drain();
        send_one(12'h000); drain();
        send_one(12'h255); drain();
        send_one(12'h100); drain();

        // Backpressure: hold the result for 5 cycles.
        out_ready = 1'b0;
        send_one(12'h042);
        wait_out_valid();
        repeat (5) @(posedge CLK);
        #1;
        chk("bp_out_valid_held", out_valid, 1);
        chk("bp_dout_held", dout, 42);
        out_ready = 1'b1;
        drain();

        // in_valid held high across two inputs.
        send(12'h007);
        send(12'h321);
        in_valid = 1'b0;
        drain();

        // Asynchronous reset in the middle of SHIFT.
        send_one(12'h987);
        repeat (4) @(posedge CLK);
        #1;
        RST = 1'b0;
        exp_q.delete();
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_dout", dout, 0);
        chk("midrst_err", err, 0);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        send_one(12'h518); drain();

`ifdef BCD_CHECK_EN
        send_one(12'h1A3); drain();
        send_one(12'h123); drain();
`endif

        rnd_mode = 1'b1;
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 3; k++) begin
                v[4*k +: 4] = 4'($urandom_range(0, 9));
            end
`ifdef BCD_CHECK_EN
            if ($urandom_range(0, 3) == 0) v[4*$urandom_range(0, 2) +: 4] = 4'($urandom_range(10, 15));
`endif
            send_one(v);
            repeat ($urandom_range(0, 2)) @(posedge CLK);
        end
        rnd_mode = 1'b0;
        @(posedge CLK);
        #2;
        out_ready = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
